// File: rtl/mt_sched_pkg.sv
// Shared types and constants for the multithreaded fetch scheduler.
package mt_sched_pkg;

   localparam int MAX_THREADS = 8;
   localparam int PEN_W       = 4;

   typedef enum logic [2:0] {
      DISABLED,
      READY,
      WAIT_I,
      WAIT_D,
      RECOVER
   } thread_state_t;

endpackage

// File: rtl/mt_fetch_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping modulo N.
module rr_arbiter
   import mt_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic         o_gnt_valid,
   output logic [W-1:0] o_gnt_idx
);

   logic [W-1:0] w_idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      o_gnt_valid = 1'b0;
      o_gnt_idx   = '0;
      w_idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = W'((int'(i_ptr) + k) % N);
         if (i_req[w_idx]) begin
            o_gnt_valid = 1'b1;
            o_gnt_idx   = w_idx;
         end
      end
   end

endmodule

// File: rtl/mt_fetch_scheduler.sv
// Per-cycle fetch thread selector with per-thread miss/recovery parking.
// Optional per-thread issue and idle counters when MT_SCHED_STATS_EN is defined.
module mt_fetch_scheduler
   import mt_sched_pkg::*;
#(
   parameter int NUM_THREADS      = 4,
   parameter int TID_W            = $clog2(NUM_THREADS),
   parameter int REDIRECT_PENALTY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_THREADS-1:0] i_thread_en,
   input  logic                   i_stall,
   input  logic                   i_imiss_valid,
   input  logic [TID_W-1:0]       i_imiss_tid,
   input  logic                   i_ifill_valid,
   input  logic [TID_W-1:0]       i_ifill_tid,
   input  logic                   i_dmiss_valid,
   input  logic [TID_W-1:0]       i_dmiss_tid,
   input  logic                   i_dfill_valid,
   input  logic [TID_W-1:0]       i_dfill_tid,
   input  logic                   i_redirect_valid,
   input  logic [TID_W-1:0]       i_redirect_tid,
   output logic                   o_fetch_valid,
   output logic [TID_W-1:0]       o_fetch_tid,
   output logic                   o_squash_valid,
   output logic [TID_W-1:0]       o_squash_tid,
   output logic [NUM_THREADS-1:0] o_thread_ready
`ifdef MT_SCHED_STATS_EN
   ,
   output logic [NUM_THREADS-1:0][31:0] o_issue_cnt,
   output logic [31:0]                  o_idle_cnt,
   input  logic                         i_stats_clr
`endif
);

   logic [NUM_THREADS-1:0] w_ready;
   logic [NUM_THREADS-1:0] w_req;
   logic                   w_gnt_valid;
   logic [TID_W-1:0]       w_gnt_idx;
   logic                   r_fetch_valid;
   logic [TID_W-1:0]       r_fetch_tid;
   logic [TID_W-1:0]       r_rr_ptr;
   logic                   r_squash_valid;
   logic [TID_W-1:0]       r_squash_tid;

   for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      thread_state_t    r_state;
      thread_state_t    w_next;
      logic [PEN_W-1:0] r_pen;
      logic [PEN_W-1:0] w_pen_next;
      logic             w_redir, w_imiss, w_dmiss, w_ifill, w_dfill, w_runnable;

      assign w_redir    = i_redirect_valid && (i_redirect_tid == TID_W'(gi));
      assign w_imiss    = i_imiss_valid    && (i_imiss_tid    == TID_W'(gi));
      assign w_dmiss    = i_dmiss_valid    && (i_dmiss_tid    == TID_W'(gi));
      assign w_ifill    = i_ifill_valid    && (i_ifill_tid    == TID_W'(gi));
      assign w_dfill    = i_dfill_valid    && (i_dfill_tid    == TID_W'(gi));
      assign w_runnable = (r_state == READY) || (r_state == RECOVER);

      always_comb begin
         w_next     = r_state;
         w_pen_next = r_pen;
         if (!i_thread_en[gi]) begin
            w_next     = DISABLED;
            w_pen_next = '0;
         end else if (w_redir && (r_state != DISABLED)) begin
            w_next     = RECOVER;
            w_pen_next = PEN_W'(REDIRECT_PENALTY - 1);
         end else if (w_runnable && w_dmiss) begin
            w_next = WAIT_D;
         end else if (w_runnable && w_imiss) begin
            w_next = WAIT_I;
         end else begin
            case (r_state)
               WAIT_I:   if (w_ifill) w_next = READY;
               WAIT_D:   if (w_dfill) w_next = READY;
               RECOVER:  if (r_pen == '0) w_next = READY;
                         else w_pen_next = r_pen - PEN_W'(1);
               DISABLED: w_next = READY;
               default:  ;
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state <= DISABLED;
            r_pen   <= '0;
         end else begin
            r_state <= w_next;
            r_pen   <= w_pen_next;
         end
      end

      // A thread leaving READY this cycle must not win this cycle's grant.
      assign w_ready[gi] = (r_state == READY);
      assign w_req[gi]   = w_ready[gi] && (w_next == READY);
   end

   rr_arbiter #(.N(NUM_THREADS), .W(TID_W)) u_arb (
      .i_req       (w_req),
      .i_ptr       (r_rr_ptr),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_idx   (w_gnt_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_valid  <= 1'b0;
         r_fetch_tid    <= '0;
         r_rr_ptr       <= '0;
         r_squash_valid <= 1'b0;
         r_squash_tid   <= '0;
      end else begin
         r_squash_valid <= i_redirect_valid;
         r_squash_tid   <= i_redirect_tid;
         if (!i_stall) begin
            r_fetch_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
               r_fetch_tid <= w_gnt_idx;
               r_rr_ptr    <= (w_gnt_idx == TID_W'(NUM_THREADS - 1)) ? '0 : w_gnt_idx + TID_W'(1);
            end
         end
      end
   end

   assign o_fetch_valid  = r_fetch_valid;
   assign o_fetch_tid    = r_fetch_tid;
   assign o_squash_valid = r_squash_valid;
   assign o_squash_tid   = r_squash_tid;
   assign o_thread_ready = w_ready;

`ifdef MT_SCHED_STATS_EN
   logic [31:0] r_idle_cnt;

   for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_stats
      logic [31:0] r_issue_cnt;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_issue_cnt <= '0;
         end else if (i_stats_clr) begin
            r_issue_cnt <= '0;
         end else if (!i_stall && w_gnt_valid && (w_gnt_idx == TID_W'(gi)) && (r_issue_cnt != '1)) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
      end
      assign o_issue_cnt[gi] = r_issue_cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle_cnt <= '0;
      end else if (i_stats_clr) begin
         r_idle_cnt <= '0;
      end else if ((w_ready == '0) && (r_idle_cnt != '1)) begin
         r_idle_cnt <= r_idle_cnt + 32'd1;
      end
   end

   assign o_idle_cnt = r_idle_cnt;
`endif

endmodule

// File: tb/tb_mt_fetch_scheduler.sv
// Scoreboard bench: a per-thread mode model predicts every registered output, a monitor compares after each edge.
module tb_mt_fetch_scheduler;

   localparam int N  = 4;
   localparam int TW = 2;
   localparam int P  = 2;
   localparam int OFF = 0, RDY = 1, WI = 2, WD = 3, REC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  i_thread_en = '0;
   logic          i_stall = 1'b0;
   logic          i_imiss_valid = 1'b0, i_ifill_valid = 1'b0, i_dmiss_valid = 1'b0;
   logic          i_dfill_valid = 1'b0, i_redirect_valid = 1'b0;
   logic [TW-1:0] i_imiss_tid = '0, i_ifill_tid = '0, i_dmiss_tid = '0;
   logic [TW-1:0] i_dfill_tid = '0, i_redirect_tid = '0;
   logic          o_fetch_valid, o_squash_valid;
   logic [TW-1:0] o_fetch_tid, o_squash_tid;
   logic [N-1:0]  o_thread_ready;
`ifdef MT_SCHED_STATS_EN
   logic [N-1:0][31:0] o_issue_cnt;
   logic [31:0]        o_idle_cnt;
   logic               i_stats_clr = 1'b0;
`endif

   always #5 clk = ~clk;

   mt_fetch_scheduler #(.NUM_THREADS(N), .TID_W(TW), .REDIRECT_PENALTY(P)) dut (
      .clk(clk), .rst(rst), .i_thread_en(i_thread_en), .i_stall(i_stall),
      .i_imiss_valid(i_imiss_valid), .i_imiss_tid(i_imiss_tid),
      .i_ifill_valid(i_ifill_valid), .i_ifill_tid(i_ifill_tid),
      .i_dmiss_valid(i_dmiss_valid), .i_dmiss_tid(i_dmiss_tid),
      .i_dfill_valid(i_dfill_valid), .i_dfill_tid(i_dfill_tid),
      .i_redirect_valid(i_redirect_valid), .i_redirect_tid(i_redirect_tid),
      .o_fetch_valid(o_fetch_valid), .o_fetch_tid(o_fetch_tid),
      .o_squash_valid(o_squash_valid), .o_squash_tid(o_squash_tid),
      .o_thread_ready(o_thread_ready)
`ifdef MT_SCHED_STATS_EN
      , .o_issue_cnt(o_issue_cnt), .o_idle_cnt(o_idle_cnt), .i_stats_clr(i_stats_clr)
`endif
   );

   typedef struct {
      logic          fv;
      logic [TW-1:0] tid;
      logic          sv;
      logic [TW-1:0] st;
      logic [N-1:0]  rdy;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   // Reference model: thread modes plus remaining recovery cycles.
   int            mode[N];
   int            left[N];
   int            rr;
   logic          exp_fv;
   logic [TW-1:0] exp_tid;

   // Stimulus for the next cycle; event valids self-clear after each tick.
   logic [N-1:0]  nx_en = '0;
   logic          nx_stall = 1'b0;
   logic          nx_imv = 0, nx_ifv = 0, nx_dmv = 0, nx_dfv = 0, nx_rv = 0;
   logic [TW-1:0] nx_imt = '0, nx_ift = '0, nx_dmt = '0, nx_dft = '0, nx_rt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < N; t++) begin
         mode[t] = OFF;
         left[t] = 0;
      end
      rr      = 0;
      exp_fv  = 1'b0;
      exp_tid = '0;
   endtask

   task automatic tick();
      int   nm[N];
      int   nl[N];
      int   pick;
      bit   found;
      exp_t e;
      @(negedge clk);
      i_thread_en = nx_en;  i_stall = nx_stall;
      i_imiss_valid = nx_imv;  i_imiss_tid = nx_imt;
      i_ifill_valid = nx_ifv;  i_ifill_tid = nx_ift;
      i_dmiss_valid = nx_dmv;  i_dmiss_tid = nx_dmt;
      i_dfill_valid = nx_dfv;  i_dfill_tid = nx_dft;
      i_redirect_valid = nx_rv; i_redirect_tid = nx_rt;
      for (int t = 0; t < N; t++) begin
         bit redir = nx_rv && (nx_rt == t);
         bit dm    = nx_dmv && (nx_dmt == t);
         bit im    = nx_imv && (nx_imt == t);
         bit runs  = (mode[t] == RDY) || (mode[t] == REC);
         nm[t] = mode[t];
         nl[t] = left[t];
         if (!nx_en[t]) begin
            nm[t] = OFF; nl[t] = 0;
         end else if (redir && mode[t] != OFF) begin
            nm[t] = REC; nl[t] = P;
         end else if (dm && runs) nm[t] = WD;
         else if (im && runs) nm[t] = WI;
         else if (mode[t] == WI && nx_ifv && nx_ift == t) nm[t] = RDY;
         else if (mode[t] == WD && nx_dfv && nx_dft == t) nm[t] = RDY;
         else if (mode[t] == REC) begin
            nl[t] = left[t] - 1;
            if (nl[t] == 0) nm[t] = RDY;
         end else if (mode[t] == OFF) nm[t] = RDY;
      end
      if (!nx_stall) begin
         found = 0;
         pick  = 0;
         for (int k = 0; k < N; k++) begin
            int c = (rr + k) % N;
            if (!found && mode[c] == RDY && nm[c] == RDY) begin
               found = 1;
               pick  = c;
            end
         end
         exp_fv = found;
         if (found) begin
            exp_tid = TW'(pick);
            rr      = (pick + 1) % N;
         end
      end
      e.fv  = exp_fv;
      e.tid = exp_tid;
      e.sv  = nx_rv;
      e.st  = nx_rt;
      for (int t = 0; t < N; t++) begin
         e.rdy[t] = (nm[t] == RDY);
         mode[t]  = nm[t];
         left[t]  = nl[t];
      end
      sb.push_back(e);
      nx_imv = 0; nx_ifv = 0; nx_dmv = 0; nx_dfv = 0; nx_rv = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      i_thread_en = '0; i_stall = 0;
      i_imiss_valid = 0; i_ifill_valid = 0; i_dmiss_valid = 0;
      i_dfill_valid = 0; i_redirect_valid = 0; i_redirect_tid = '0;
      #1;
      chk("rst_fetch_valid", 32'(o_fetch_valid), 0);
      chk("rst_fetch_tid", 32'(o_fetch_tid), 0);
      chk("rst_squash_valid", 32'(o_squash_valid), 0);
      chk("rst_squash_tid", 32'(o_squash_tid), 0);
      chk("rst_thread_ready", 32'(o_thread_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      nx_en = '0; nx_stall = 0; nx_rt = '0;
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("fetch_valid", 32'(o_fetch_valid), 32'(e.fv));
         chk("fetch_tid", 32'(o_fetch_tid), 32'(e.tid));
         chk("squash_valid", 32'(o_squash_valid), 32'(e.sv));
         chk("squash_tid", 32'(o_squash_tid), 32'(e.st));
         chk("thread_ready", 32'(o_thread_ready), 32'(e.rdy));
         $display("t=%0t fetch v=%0b tid=%0d squash v=%0b tid=%0d ready=%b", $time,
                  o_fetch_valid, o_fetch_tid, o_squash_valid, o_squash_tid, o_thread_ready);
      end
   end

   initial begin
      model_reset();
      apply_reset();

      nx_en = 4'b1111;
      repeat (10) tick();
      nx_en = 4'b1010;
      repeat (8) tick();

      nx_en = 4'b1111;
      repeat (3) tick();
      nx_imv = 1; nx_imt = 2; tick();
      repeat (6) tick();
      nx_ifv = 1; nx_ift = 2; tick();
      repeat (5) tick();

      nx_rv = 1; nx_rt = 1; tick();
      repeat (6) tick();

      for (int t = 0; t < N; t++) begin
         nx_dmv = 1; nx_dmt = TW'(t); tick();
      end
      repeat (4) tick();
      for (int t = 0; t < N; t++) begin
         nx_dfv = 1; nx_dft = TW'(t); tick();
      end
      repeat (4) tick();

      for (int i = 0; i < 8 && !(exp_fv && exp_tid == 2); i++) tick();
      nx_stall = 1;
      repeat (3) tick();
      nx_stall = 0;
      repeat (4) tick();

      nx_imv = 1; nx_imt = 1; tick();
      tick();
      apply_reset();
      nx_ifv = 1; nx_ift = 1; tick();
      nx_en = 4'b1111;
      repeat (4) tick();

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) nx_en = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 19) == 0) nx_en = 4'b1111;
         nx_stall = ($urandom_range(0, 9) == 0);
         nx_imv = ($urandom_range(0, 6) == 0); nx_imt = TW'($urandom_range(0, N - 1));
         nx_ifv = ($urandom_range(0, 3) == 0); nx_ift = TW'($urandom_range(0, N - 1));
         nx_dmv = ($urandom_range(0, 6) == 0); nx_dmt = TW'($urandom_range(0, N - 1));
         nx_dfv = ($urandom_range(0, 3) == 0); nx_dft = TW'($urandom_range(0, N - 1));
         nx_rv  = ($urandom_range(0, 7) == 0); nx_rt  = TW'($urandom_range(0, N - 1));
         tick();
      end
      nx_stall = 0;
      repeat (3) tick();

      @(posedge clk);
      #3;
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
